rv_wb_master_bridge: RTL and testbench

- Sits directly downstream of the RV32I core's data-memory port.
- Converts the core's level-held mem_req/mem_ready stall handshake into single Wishbone B4 classic master cycles toward the NoC network interface.
- Latches each request, runs exactly one bus cycle per request, and returns a one-cycle mem_ready pulse with registered read data.
- A bus error or timeout completes the access, so the single-cycle core can never hang.

---
 rtl/rv_wb_master_bridge.sv | 152 +++++++++++++++
 tb/tb_rv_wb_master_bridge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_wb_master_bridge.sv
// rv_wb_master_bridge: turns the RV32I data-port stall handshake into single
// Wishbone B4 classic master cycles. One request in, one bus cycle out, one
// mem_ready pulse back. Bus errors (and timeouts, when enabled) still complete
// the access so the core never hangs.
//
// Build option: define WB_TIMEOUT_EN to add the ack-wait timeout counter.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access in flight; mem_req sampled here only
// BUS   | Wishbone cycle open, request fields held stable on wb_*_o
// RESP  | mem_ready pulse to the core, mem_rdata valid
module rv_wb_master_bridge #(
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_be,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   done;
  logic   fail;
  logic   tmo_hit;

  // The counter is 16 bits wide, so larger limits cannot be honoured.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  // The byte offset within the word never reaches the bus; lanes come via mem_be.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr[1:0];

`ifdef WB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Count BUS cycles without a slave response; held at zero outside BUS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state_q != BUS) begin
      tmo_cnt <= '0;
    end else if (!wb_ack_i && !wb_err_i) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th BUS cycle.
  assign tmo_hit = (state_q == BUS) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a real ack on the timeout cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    fail    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          accept  = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        fail = wb_err_i || (tmo_hit && !wb_ack_i);
        done = wb_ack_i || fail;
        if (done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus-side request latch, response capture and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (accept) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= mem_we;
        wb_adr_o <= {mem_addr[31:2], 2'b00};
        wb_dat_o <= mem_we ? mem_wdata : 32'h0;
        wb_sel_o <= mem_we ? mem_be : 4'hF;
      end
      if (done) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        if (fail) begin
          mem_rdata <= ERR_RDATA;
          bus_err   <= 1'b1;
        end else begin
          mem_rdata <= wb_we_o ? 32'h0 : wb_dat_i;
        end
      end
    end
  end

  assign mem_ready = (state_q == RESP);

endmodule

// File: tb/tb_rv_wb_master_bridge.sv
// Scoreboard bench for rv_wb_master_bridge. Stimulus pushes the expected
// completion (read data, bus_err, cycle of the mem_ready pulse) into a queue;
// a negedge monitor pops and compares whenever mem_ready is seen.
`timescale 1ns/1ps
module tb_rv_wb_master_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_be = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        bus_err;

  rv_wb_master_bridge #(
    .ERR_RDATA      (32'hDEAD_BEEF),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;
  logic err_model = 1'b0;
  logic prev_ready = 1'b0;

  // slave model controls
  int          slv_waits = 0;
  logic [31:0] slv_data = '0;
  logic        slv_err = 1'b0;
  logic        slv_silent = 1'b0;
  int          slv_cnt = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Wishbone slave: responds after slv_waits wait states, err raised together with ack.
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && !slv_silent) begin
      if (slv_cnt == slv_waits) begin
        wb_ack_i = 1'b1;
        wb_err_i = slv_err;
        wb_dat_i = slv_data;
        slv_cnt  = 0;
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'hFFFF_FFFF;
        slv_cnt  = slv_cnt + 1;
      end
    end else begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'hFFFF_FFFF;
      slv_cnt  = 0;
    end
  end

  // Monitor: every mem_ready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mem_ready) begin
      chk("ready_width", {31'b0, prev_ready}, 32'd0);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got mem_ready=1 expected none (cycle %0d)", cyc_n);
      end else begin
        e = sb_q.pop_front();
        chk("mem_rdata", mem_rdata, e.rdata);
        chk("bus_err", {31'b0, bus_err}, {31'b0, e.err});
        chk("ready_cycle", cyc_n, e.cyc);
      end
    end
    prev_ready = mem_ready;
  end

  task automatic wait_ready(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (mem_ready) seen = 1;
    end
    chk("ready_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] exp_adr,
                           input logic [3:0] exp_sel, input logic [31:0] sdata,
                           input int waits, input logic serr, input logic [31:0] exp_rdata);
    exp_t e;
    @(negedge clk);
    slv_waits = waits;
    slv_data  = sdata;
    slv_err   = serr;
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_be    = be;
    err_model = err_model | serr;
    e.rdata = exp_rdata;
    e.err   = err_model;
    e.cyc   = cyc_n + 2 + waits;
    sb_q.push_back(e);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk("wb_cyc", {31'b0, wb_cyc_o}, 32'd1);
      chk("wb_stb", {31'b0, wb_stb_o}, 32'd1);
      chk("wb_we", {31'b0, wb_we_o}, {31'b0, we});
      chk("wb_adr", wb_adr_o, exp_adr);
      chk("wb_dat", wb_dat_o, we ? wdata : 32'h0);
      chk("wb_sel", {28'b0, wb_sel_o}, {28'b0, exp_sel});
    end
    wait_ready(4);
    chk("cyc_in_resp", {31'b0, wb_cyc_o}, 32'd0);
    mem_req = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   gap;

    // reset state
    #12;
    chk("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'b0, wb_stb_o}, 32'd0);
    chk("rst_we", {31'b0, wb_we_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_sel", {28'b0, wb_sel_o}, 32'd0);
    chk("rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // load, zero-wait slave
    do_access(1'b0, 32'h1000_0006, 32'h0, 4'h0, 32'h1000_0004, 4'hF,
              32'h1234_5678, 0, 1'b0, 32'h1234_5678);
    // store, three wait states; store data from the slave must not appear on mem_rdata
    do_access(1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 32'h0000_0020, 4'b0010,
              32'h5555_5555, 3, 1'b0, 32'h0000_0000);

    // back-to-back loads with mem_req held high
    @(negedge clk);
    slv_waits = 0;
    slv_err   = 1'b0;
    slv_data  = 32'h0A0A_0001;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0100;
    e.rdata = 32'h0A0A_0001; e.err = err_model; e.cyc = cyc_n + 2; sb_q.push_back(e);
    e.rdata = 32'h0B0B_0002; e.err = err_model; e.cyc = cyc_n + 5; sb_q.push_back(e);
    @(negedge clk);
    chk("b2b_adr0", wb_adr_o, 32'h0000_0100);
    wait_ready(4);
    // core advances on the RESP edge: next instruction's address, req still high
    mem_addr = 32'h0000_0206;
    slv_data = 32'h0B0B_0002;
    gap = wb_cyc_o ? 0 : 1;
    @(negedge clk);
    if (!wb_cyc_o) gap++;
    @(negedge clk);
    chk("b2b_cyc1", {31'b0, wb_cyc_o}, 32'd1);
    chk("b2b_adr1", wb_adr_o, 32'h0000_0204);
    // the RESP clock and the IDLE clock separate the two bus cycles
    chk("b2b_gap", gap, 32'd2);
    wait_ready(4);
    mem_req = 1'b0;

    // error with ack, then a good access keeps bus_err set
    do_access(1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h0000_0300, 4'hF,
              32'h1111_1111, 1, 1'b1, 32'hDEAD_BEEF);
    do_access(1'b0, 32'h0000_0304, 32'h0, 4'h0, 32'h0000_0304, 4'hF,
              32'h2222_2222, 0, 1'b0, 32'h2222_2222);

    // reset while the bus cycle is open
    @(negedge clk);
    slv_silent = 1'b1;
    mem_req    = 1'b1;
    mem_we     = 1'b0;
    mem_addr   = 32'h0000_0400;
    repeat (2) @(negedge clk);
    chk("pre_rst_cyc", {31'b0, wb_cyc_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("mid_rst_stb", {31'b0, wb_stb_o}, 32'd0);
    chk("mid_rst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("mid_rst_rdata", mem_rdata, 32'd0);
    err_model  = 1'b0;
    mem_req    = 1'b0;
    slv_silent = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", {31'b0, mem_ready}, 32'd0);
    end
    do_access(1'b0, 32'h0000_0404, 32'h0, 4'h0, 32'h0000_0404, 4'hF,
              32'h3333_3333, 2, 1'b0, 32'h3333_3333);

    // slave that never answers
    @(negedge clk);
    slv_silent = 1'b1;
    mem_req    = 1'b1;
    mem_we     = 1'b0;
    mem_addr   = 32'h0000_0500;
`ifdef WB_TIMEOUT_EN
    err_model = 1'b1;
    e.rdata = 32'hDEAD_BEEF; e.err = 1'b1; e.cyc = cyc_n + 9; sb_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("tmo_cyc_open", {31'b0, wb_cyc_o}, 32'd1);
    end
    wait_ready(3);
    chk("tmo_cyc_drop", {31'b0, wb_cyc_o}, 32'd0);
`else
    repeat (40) @(negedge clk);
    chk("stall_cyc", {31'b0, wb_cyc_o}, 32'd1);
    chk("stall_ready", {31'b0, mem_ready}, 32'd0);
    @(posedge clk);
    #1;
    slv_waits  = 0;
    slv_err    = 1'b0;
    slv_data   = 32'h4444_4444;
    slv_silent = 1'b0;
    e.rdata = 32'h4444_4444; e.err = err_model; e.cyc = cyc_n + 1; sb_q.push_back(e);
    wait_ready(4);
`endif
    mem_req    = 1'b0;
    slv_silent = 1'b0;

    // drain the scoreboard
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case something wedges the stimulus
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
